// File: rtl/uart_tx_feeder.sv
// Byte FIFO and launch controller feeding the UART bit transmitter over a
// one-cycle start/done handshake; reports FIFO status, sticky errors and a sent-byte count.
//
// state  | meaning
// S_IDLE | no byte in flight; launches the FIFO head when non-empty and not flushing
// S_BUSY | byte handed to transmitter; waiting for tx_done or the timeout
module uart_tx_feeder #(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 16,
  parameter int TIMEOUT   = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [DATA_BITS-1:0]   wr_data,
  input  logic                   flush,
  input  logic                   clear_err,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic                   tx_start,
  output logic [DATA_BITS-1:0]   tx_data,
  input  logic                   tx_done,
  output logic                   busy,
  output logic                   timeout_err,
  output logic [15:0]            sent_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int TW = $clog2(TIMEOUT);

  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMR_ONE  = TW'(1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t               state;
  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [LW-1:0]        level_q;
  logic [TW-1:0]        timer;

  logic push_ok;
  logic push_drop;
  logic launch;
  logic tmo_evt;

  // flush suppresses both the push and the launch in its cycle
  always_comb begin
    push_ok   = 1'b0;
    push_drop = 1'b0;
    launch    = 1'b0;
    tmo_evt   = 1'b0;
    if (wr_en && !flush) begin
      push_ok   = (level_q != LVL_FULL);
      push_drop = (level_q == LVL_FULL);
    end
    launch  = (state == S_IDLE) && (level_q != '0) && !flush;
    tmo_evt = (state == S_BUSY) && !tx_done && (timer == TMR_LAST);
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level_q  <= '0;
      overflow <= 1'b0;
    end else begin
      if (flush) begin
        rd_ptr  <= wr_ptr;
        level_q <= '0;
      end else begin
        if (push_ok) begin
          wr_ptr <= wr_ptr + PTR_ONE;
        end
        if (launch) begin
          rd_ptr <= rd_ptr + PTR_ONE;
        end
        if (push_ok && !launch) begin
          level_q <= level_q + LVL_ONE;
        end else if (!push_ok && launch) begin
          level_q <= level_q - LVL_ONE;
        end
      end
      if (push_drop) begin
        overflow <= 1'b1;
      end else if (clear_err) begin
        overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      timer       <= '0;
      sent_count  <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          tx_start <= 1'b0;
          if (launch) begin
            tx_data  <= mem[rd_ptr];
            tx_start <= 1'b1;
            timer    <= '0;
            state    <= S_BUSY;
          end
        end
        S_BUSY: begin
          tx_start <= 1'b0;
          timer    <= timer + TMR_ONE;
          // done in the last timeout cycle still counts as a good completion
          if (tx_done) begin
            sent_count <= sent_count + 16'd1;
            state      <= S_IDLE;
          end else if (timer == TMR_LAST) begin
            state <= S_IDLE;
          end
        end
        default: begin
          tx_start <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
      if (tmo_evt) begin
        timeout_err <= 1'b1;
      end else if (clear_err) begin
        timeout_err <= 1'b0;
      end
    end
  end

  assign level = level_q;
  assign full  = (level_q == LVL_FULL);
  assign empty = (level_q == '0);
  assign busy  = (state == S_BUSY);

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed self-checking bench for uart_tx_feeder with DATA_BITS=8, DEPTH=16, TIMEOUT=64.
module tb_uart_tx_feeder;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        flush;
  logic        clear_err;
  logic        full;
  logic        empty;
  logic [4:0]  level;
  logic        overflow;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        busy;
  logic        timeout_err;
  logic [15:0] sent_count;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_feeder #(.DATA_BITS(8), .DEPTH(16), .TIMEOUT(64)) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .flush       (flush),
    .clear_err   (clear_err),
    .full        (full),
    .empty       (empty),
    .level       (level),
    .overflow    (overflow),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .busy        (busy),
    .timeout_err (timeout_err),
    .sent_count  (sent_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    wr_en     = 1'b0;
    flush     = 1'b0;
    clear_err = 1'b0;
    tx_done   = 1'b0;
    reset     = 1'b0;
    #3;
    reset     = 1'b1;
    tick();
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0; clear_err = 1'b0; tx_done = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("rst_level",    32'(level), 0);
    check("rst_empty",    32'(empty), 1);
    check("rst_full",     32'(full), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_tx_start", 32'(tx_start), 0);
    check("rst_tx_data",  32'(tx_data), 0);
    check("rst_busy",     32'(busy), 0);
    check("rst_timeout",  32'(timeout_err), 0);
    check("rst_sent",     32'(sent_count), 0);
    #1 reset = 1'b1;
    tick();

    // single byte launch and completion
    tick();
    wr_en = 1'b1; wr_data = 8'h55; tick(); wr_en = 1'b0;
    check("t1_level_push", 32'(level), 1);
    check("t1_no_start",   32'(tx_start), 0);
    tick();
    check("t1_start", 32'(tx_start), 1);
    check("t1_data",  32'(tx_data), 'h55);
    check("t1_busy",  32'(busy), 1);
    check("t1_empty", 32'(empty), 1);
    tick();
    check("t1_pulse_width", 32'(tx_start), 0);
    repeat (10) tick();
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    check("t1_idle",      32'(busy), 0);
    check("t1_sent",      32'(sent_count), 1);
    check("t1_empty_end", 32'(empty), 1);
    check("t1_data_hold", 32'(tx_data), 'h55);
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    check("t1_done_idle_ignored", 32'(sent_count), 1);

    // three bytes back to back, one idle cycle between characters
    do_reset();
    wr_en = 1'b1; wr_data = 8'h41; tick();
    wr_data = 8'h42; tick();
    check("t2_start0", 32'(tx_start), 1);
    check("t2_data0",  32'(tx_data), 'h41);
    wr_data = 8'h43; tick(); wr_en = 1'b0;
    check("t2_start0_low", 32'(tx_start), 0);
    check("t2_level2",     32'(level), 2);
    repeat (3) tick();
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    check("t2_gap_start", 32'(tx_start), 0);
    check("t2_gap_busy",  32'(busy), 0);
    check("t2_sent1",     32'(sent_count), 1);
    tick();
    check("t2_start1", 32'(tx_start), 1);
    check("t2_data1",  32'(tx_data), 'h42);
    check("t2_level1", 32'(level), 1);
    repeat (4) tick();
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    check("t2_gap2_start", 32'(tx_start), 0);
    tick();
    check("t2_start2", 32'(tx_start), 1);
    check("t2_data2",  32'(tx_data), 'h43);
    repeat (2) tick();
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    check("t2_sent3",  32'(sent_count), 3);
    check("t2_idle",   32'(busy), 0);
    check("t2_empty",  32'(empty), 1);
    tick();
    check("t2_no_extra_start", 32'(tx_start), 0);

    // fill to full while one byte is in flight, then overflow
    do_reset();
    wr_en = 1'b1; wr_data = 8'hA0; tick(); wr_en = 1'b0;
    tick();
    check("t3_busy", 32'(busy), 1);
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h30 + i); tick();
    end
    wr_en = 1'b0;
    check("t3_full",        32'(full), 1);
    check("t3_level16",     32'(level), 16);
    check("t3_no_overflow", 32'(overflow), 0);
    wr_en = 1'b1; wr_data = 8'hEE; tick(); wr_en = 1'b0;
    check("t3_overflow",    32'(overflow), 1);
    check("t3_level_held",  32'(level), 16);
    clear_err = 1'b1; tick(); clear_err = 1'b0;
    check("t3_overflow_clr", 32'(overflow), 0);
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    check("t3_sent1", 32'(sent_count), 1);
    tick();
    check("t3_head_start", 32'(tx_start), 1);
    check("t3_head_data",  32'(tx_data), 'h30);
    check("t3_level15",    32'(level), 15);
    wr_en = 1'b1; wr_data = 8'h50; tick();
    check("t3_refull", 32'(full), 1);
    clear_err = 1'b1; tick(); clear_err = 1'b0; wr_en = 1'b0;
    check("t3_set_beats_clear", 32'(overflow), 1);

    // handshake timeout, then next byte launches; done on the last cycle wins
    do_reset();
    wr_en = 1'b1; wr_data = 8'h11; tick();
    wr_data = 8'h22; tick(); wr_en = 1'b0;
    check("t4_start", 32'(tx_start), 1);
    check("t4_data",  32'(tx_data), 'h11);
    repeat (63) tick();
    check("t4_no_early_timeout", 32'(timeout_err), 0);
    check("t4_still_busy",       32'(busy), 1);
    tick();
    check("t4_timeout",  32'(timeout_err), 1);
    check("t4_idle",     32'(busy), 0);
    check("t4_sent0",    32'(sent_count), 0);
    tick();
    check("t4_next_start", 32'(tx_start), 1);
    check("t4_next_data",  32'(tx_data), 'h22);
    clear_err = 1'b1; tick(); clear_err = 1'b0;
    check("t4_timeout_clr", 32'(timeout_err), 0);
    repeat (62) tick();
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    check("t4_done_wins_err",  32'(timeout_err), 0);
    check("t4_done_wins_sent", 32'(sent_count), 1);
    check("t4_done_wins_idle", 32'(busy), 0);

    // flush with simultaneous push, in-flight byte still completes
    do_reset();
    wr_en = 1'b1; wr_data = 8'h70; tick(); wr_en = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h71 + i); tick();
    end
    wr_en = 1'b0;
    check("t5_level5", 32'(level), 5);
    wr_en = 1'b1; wr_data = 8'h99; flush = 1'b1; tick(); wr_en = 1'b0; flush = 1'b0;
    check("t5_level0",      32'(level), 0);
    check("t5_empty",       32'(empty), 1);
    check("t5_no_overflow", 32'(overflow), 0);
    check("t5_busy",        32'(busy), 1);
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    check("t5_sent1", 32'(sent_count), 1);
    tick();
    check("t5_no_start", 32'(tx_start), 0);
    check("t5_idle",     32'(busy), 0);

    // asynchronous reset while busy with queued bytes
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h80 + i); tick();
    end
    wr_en = 1'b0;
    check("t6_level3", 32'(level), 3);
    check("t6_busy",   32'(busy), 1);
    check("t6_data",   32'(tx_data), 'h80);
    #2 reset = 1'b0;
    #1;
    check("t6_rst_level", 32'(level), 0);
    check("t6_rst_empty", 32'(empty), 1);
    check("t6_rst_busy",  32'(busy), 0);
    check("t6_rst_data",  32'(tx_data), 0);
    check("t6_rst_start", 32'(tx_start), 0);
    #1 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_no_start_after", 32'(tx_start), 0);
    end
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    check("t6_sent0", 32'(sent_count), 0);
    check("t6_idle",  32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
